// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide unit that owns the HI/LO
// registers. Multiply is shift-add into a 2*WIDTH accumulator; divide is
// restoring, one quotient bit per cycle.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV via
// sign/magnitude conversion). Without it, MulDivOp[1] is ignored and the
// negation logic is not built.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for Start; MTHI/MTLO writes accepted
// S_RUN  | iterating, counter 0..31; HI/LO frozen; Busy high
// S_DONE | one cycle, Done high; Start or MTHI/MTLO accepted as in IDLE

module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       MulDivOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WriteHi,
   input  logic             WriteLo,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     a_raw_q, a_raw_d;
   logic                 is_div_q, is_div_d;
   logic                 zero_div_q, zero_div_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 dbz_q, dbz_d;

`ifdef MULDIV_SIGNED_EN
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 a_neg, b_neg;
`else
   logic                 op_sign_unused;
`endif

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH-1:0]     div_diff;
   logic                 div_fits;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;
   logic [2*WIDTH-1:0]   prod_fin;
   logic [WIDTH-1:0]     quo_fin, rem_fin;
   logic [WIDTH-1:0]     res_hi, res_lo;

   // Operand magnitudes presented to the iterative core at Start.
`ifdef MULDIV_SIGNED_EN
   always_comb begin
      a_neg = MulDivOp[1] & A[WIDTH-1];
      b_neg = MulDivOp[1] & B[WIDTH-1];
      a_mag = a_neg ? -A : A;
      b_mag = b_neg ? -B : B;
   end
`else
   assign op_sign_unused = MulDivOp[1];
   always_comb begin
      a_mag = A;
      b_mag = B;
   end
`endif

   // One iteration of shift-add multiply and restoring divide, plus the
   // final sign fix-up applied on the last iteration.
   always_comb begin
      // acc = {partial product, remaining multiplier bits}
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      // acc = {partial remainder, dividend bits / quotient bits}
      div_fits = (acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q});
      div_diff = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;
      div_next = div_fits ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};
      step_next = is_div_q ? div_next : mul_next;

      prod_fin = step_next;
      quo_fin  = step_next[WIDTH-1:0];
      rem_fin  = step_next[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
      if (neg_res_q) begin
         prod_fin = -step_next;
         quo_fin  = -step_next[WIDTH-1:0];
      end
      if (neg_rem_q) begin
         rem_fin = -step_next[2*WIDTH-1:WIDTH];
      end
`endif

      if (!is_div_q) begin
         res_hi = prod_fin[2*WIDTH-1:WIDTH];
         res_lo = prod_fin[WIDTH-1:0];
      end else if (zero_div_q) begin
         // divide by zero reports the dividend exactly as it was presented
         res_hi = a_raw_q;
         res_lo = '1;
      end else begin
         res_hi = rem_fin;
         res_lo = quo_fin;
      end
   end

   // Next-state and register-update logic for the controller.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      a_raw_d    = a_raw_q;
      is_div_d   = is_div_q;
      zero_div_d = zero_div_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dbz_d      = dbz_q;
`ifdef MULDIV_SIGNED_EN
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
`endif

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               // Start has priority; any concurrent MTHI/MTLO is dropped
               state_d    = S_RUN;
               cnt_d      = '0;
               dbz_d      = 1'b0;
               is_div_d   = MulDivOp[0];
               zero_div_d = (B == '0);
               a_raw_d    = A;
               if (MulDivOp[0]) begin
                  acc_d  = {{WIDTH{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, b_mag};
                  opnd_d = a_mag;
               end
`ifdef MULDIV_SIGNED_EN
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
`endif
            end else begin
               state_d = S_IDLE;
               if (WriteHi) hi_d = A;
               if (WriteLo) lo_d = A;
            end
         end
         S_RUN: begin
            acc_d = step_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               hi_d    = res_hi;
               lo_d    = res_lo;
               dbz_d   = is_div_q & zero_div_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         a_raw_q    <= '0;
         is_div_q   <= 1'b0;
         zero_div_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         dbz_q      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         a_raw_q    <= a_raw_d;
         is_div_q   <= is_div_d;
         zero_div_q <= zero_div_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dbz_q      <= dbz_d;
`ifdef MULDIV_SIGNED_EN
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
`endif
      end
   end

   assign Busy      = (state_q == S_RUN);
   assign Done      = (state_q == S_DONE);
   assign DivByZero = dbz_q;
   assign HI        = hi_q;
   assign LO        = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the execute stage of the MIPS datapath. It sits alongside the ALU: it takes the same rs/rt operands and owns the architectural HI/LO registers. It stalls the pipeline through `Busy` while a MULT/DIV runs. Its HI/LO outputs feed the write-back result mux for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. One clock, sampled on the rising edge of `clk`.
- `Start`  in  1  launch the operation selected by `MulDivOp`. Sampled only in IDLE or DONE.
- `MulDivOp`  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `A`  in  WIDTH  rs operand (multiplicand/dividend). Also the MTHI/MTLO source.
- `B`  in  WIDTH  rt operand (multiplier/divisor).
- `WriteHi`  in  1  MTHI: load `A` into HI.
- `WriteLo`  in  1  MTLO: load `A` into LO.
- `Busy`  out  1  high in RUN. Used as the pipeline stall request.
- `Done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `DivByZero`  out  1  registered. Set on completion of a DIV/DIVU with B=0; cleared by the next Start.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
States:
- IDLE (reset state).
- RUN (6-bit counter, 0..31).
- DONE (one cycle).

Transitions:
- IDLE/DONE + `Start` → RUN. Operands are latched, the counter is cleared, and `DivByZero` is cleared.
- DONE without `Start` → IDLE.
- RUN with counter = 31 → DONE. HI/LO are written on that edge.

Multiply:
- Shift-add over 32 iterations into a 64-bit accumulator.
- HI = product[63:32], LO = product[31:0].

Divide:
- Restoring, one quotient bit per iteration.
- LO = quotient, HI = remainder.

Signed ops (MULT/DIV):
- Operands are converted to magnitudes before iterating.
- Product and quotient are negated if sign(A) XOR sign(B).
- Remainder takes the sign of A.

Boundary conditions:
- Divide by zero (either signedness): runs the full latency. Result is HI = A as presented, LO = 32'hFFFFFFFF, and `DivByZero` is set.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No exception.
- `Start` during RUN is ignored. No queueing.
- `WriteHi`/`WriteLo` in IDLE or DONE: HI/LO take `A` on the next edge. Both may be asserted together.
- `WriteHi`/`WriteLo` during RUN are ignored.
- `Start` together with `WriteHi`/`WriteLo`: `Start` wins and the writes are dropped.
- Reset (any state, including mid-RUN) returns to IDLE with HI = 0, LO = 0, `Busy` = 0, `Done` = 0, `DivByZero` = 0, and counter = 0. The aborted result is never written.

## Timing
Let edge 0 be the edge on which `Start` is sampled.
- Edges 1..32: `Busy` = 1 after edge 0 through edge 32.
- Edge 32: HI/LO are updated and the state enters DONE.
- `Done` = 1 and `Busy` = 0 for the one cycle after edge 32.

Latency and throughput:
- Latency is 32 cycles from the accepted `Start` to the `Done` cycle, independent of operands.
- `Start` asserted during the DONE cycle is accepted. Back-to-back throughput is one op per 33 cycles.

Output timing:
- All outputs are registered. No combinational path from inputs to outputs.
- HI/LO hold their value while in RUN.
- MFHI/MFLO read HI/LO directly, so the pipeline must honour `Busy`.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT/DIV use sign/magnitude conversion as above.
- `MULDIV_SIGNED_EN` undefined: `MulDivOp[1]` is ignored. MULT behaves as MULTU and DIV behaves as DIVU. The negation logic is not synthesised.
- Latency is identical in both builds.

## Test plan
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF → `Busy` for 32 cycles, then `Done` with HI=32'hFFFFFFFE, LO=32'h00000001.
- DIVU A=100, B=7 → LO=14, HI=2, `DivByZero`=0. Then DIVU A=5, B=0 → HI=5, LO=32'hFFFFFFFF, `DivByZero`=1.
- Signed ops (macro defined):
  - MULT A=-3, B=5 → HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
  - DIV A=-7, B=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - With the macro undefined, DIV A=-7, B=2 gives the DIVU result: LO=32'h7FFFFFFC, HI=1.
- MTHI/MTLO: `WriteHi` with A=32'h12345678 in IDLE → HI updates next edge. `WriteLo` asserted during RUN → LO unchanged and the final result lands.
- Start handling:
  - `Start` re-asserted mid-RUN is ignored: exactly one `Done`, and the result uses the first operands.
  - `Start` in the DONE cycle begins a new RUN immediately.
- Reset low at RUN counter=10 → next cycle IDLE with HI=LO=0 and `Busy`=`Done`=0. No `Done` pulse follows.
